// File: rtl/add_acc_pkg.sv
// ---------------------------------------------------------------------------
// add_acc_pkg : shared FSM state type and default widths for add_accumulator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package add_acc_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

endpackage

`default_nettype wire

// File: rtl/add_accumulator_rca.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder : bit-serial-carry adder with explicit carry in/out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ripple_carry_adder
  import add_acc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  c_in,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  c_out
);

  logic w_carry;

  always_comb begin
    sum     = '0;
    w_carry = c_in;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      sum[i]  = a[i] ^ b[i] ^ w_carry;
      w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
    end
    c_out = w_carry;
  end

endmodule

`default_nettype wire

// File: rtl/add_accumulator.sv
// ---------------------------------------------------------------------------
// add_accumulator : streaming block accumulator with sticky overflow and
//                   saturating operand count. Optional: ADD_ACC_SATURATE_EN
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module add_accumulator
  import add_acc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  out_ovf,
  output logic [CNT_WIDTH-1:0]  out_count
);

  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;

  acc_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic [DATA_WIDTH-1:0] w_add_a;
  logic [DATA_WIDTH-1:0] w_sum;
  logic                  w_c_out;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_acc_next;

  // The first operand of a block is added to zero so no stale sum leaks in.
  assign w_add_a = (state_q == IDLE) ? '0 : acc_q;

  ripple_carry_adder #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_adder (
    .a     (w_add_a),
    .b     (in_data),
    .c_in  (1'b0),
    .sum   (w_sum),
    .c_out (w_c_out)
  );

`ifdef ADD_ACC_SATURATE_EN
  assign w_acc_next = w_c_out ? '1 : w_sum;
`else
  assign w_acc_next = w_sum;
`endif

  assign in_ready  = !rst && (state_q != DONE);
  assign out_valid = !rst && (state_q == DONE);
  assign w_accept  = in_valid && in_ready;

  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = count_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (w_accept) begin
          acc_d   = w_acc_next;
          state_d = in_last ? DONE : ACCUM;
          if (state_q == IDLE) begin
            ovf_d   = w_c_out;
            count_d = C_CNT_ONE;
          end else begin
            ovf_d   = ovf_q | w_c_out;
            count_d = (count_q == C_CNT_MAX) ? C_CNT_MAX : count_q + C_CNT_ONE;
          end
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_add_accumulator.sv
// ---------------------------------------------------------------------------
// tb_add_accumulator : directed table-driven bench for add_accumulator (8/4)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_add_accumulator;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_sum;
  logic          out_ovf;
  logic [CW-1:0] out_count;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  add_accumulator #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  typedef struct {
    int                  n;
    logic [3:0][DW-1:0]  ops;
    logic [DW-1:0]       exp_sum;
    logic [DW-1:0]       exp_sum_sat;
    logic                exp_ovf;
    logic [CW-1:0]       exp_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand for exactly one edge; in_ready must be high at that edge.
  task automatic send_op(input logic [DW-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    chk("in_ready_before_accept", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  function automatic logic [DW-1:0] pick(input logic [DW-1:0] wrap, input logic [DW-1:0] sat);
`ifdef ADD_ACC_SATURATE_EN
    return sat;
`else
    return wrap;
`endif
  endfunction

  vec_t vecs[6];

  initial begin
    vecs[0] = '{n:3, ops:{8'd0,   8'd7,   8'd5,   8'd3},   exp_sum:8'd15,  exp_sum_sat:8'd15,  exp_ovf:1'b0, exp_cnt:4'd3};
    vecs[1] = '{n:2, ops:{8'd0,   8'd0,   8'd100, 8'd200}, exp_sum:8'd44,  exp_sum_sat:8'd255, exp_ovf:1'b1, exp_cnt:4'd2};
    vecs[2] = '{n:1, ops:{8'd0,   8'd0,   8'd0,   8'd42},  exp_sum:8'd42,  exp_sum_sat:8'd42,  exp_ovf:1'b0, exp_cnt:4'd1};
    vecs[3] = '{n:3, ops:{8'd0,   8'd1,   8'd127, 8'd128}, exp_sum:8'd0,   exp_sum_sat:8'd255, exp_ovf:1'b1, exp_cnt:4'd3};
    vecs[4] = '{n:4, ops:{8'd40,  8'd30,  8'd20,  8'd10},  exp_sum:8'd100, exp_sum_sat:8'd100, exp_ovf:1'b0, exp_cnt:4'd4};
    vecs[5] = '{n:3, ops:{8'd0,   8'd5,   8'd100, 8'd200}, exp_sum:8'd49,  exp_sum_sat:8'd255, exp_ovf:1'b1, exp_cnt:4'd3};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready",  in_ready,  1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum",       out_sum,   0);
    chk("rst_ovf",       out_ovf,   1'b0);
    chk("rst_count",     out_count, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1'b1);

    // Table-driven blocks, downstream always ready
    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        if (k != vecs[v].n - 1) begin
          send_op(vecs[v].ops[k], 1'b0);
          chk("accum_out_valid_low", out_valid, 1'b0);
        end else begin
          send_op(vecs[v].ops[k], 1'b1);
        end
      end
      chk("vec_out_valid", out_valid, 1'b1);
      chk("vec_in_ready",  in_ready,  1'b0);
      chk("vec_sum",       out_sum,   pick(vecs[v].exp_sum, vecs[v].exp_sum_sat));
      chk("vec_ovf",       out_ovf,   vecs[v].exp_ovf);
      chk("vec_count",     out_count, vecs[v].exp_cnt);
      tick();
      chk("vec_back_idle_valid", out_valid, 1'b0);
      chk("vec_back_idle_ready", in_ready,  1'b1);
    end

    // Back-pressure in DONE: outputs hold and offered operands are refused
    out_ready = 1'b0;
    send_op(8'd1, 1'b0);
    send_op(8'd2, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'd99;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_in_ready",  in_ready,  1'b0);
      chk("stall_sum",       out_sum,   3);
      chk("stall_count",     out_count, 2);
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    chk("stall_release_valid", out_valid, 1'b1);
    tick();
    chk("stall_idle_valid", out_valid, 1'b0);
    chk("stall_idle_ready", in_ready,  1'b1);
    chk("stall_idle_sum",   out_sum,   3);
    chk("stall_idle_count", out_count, 2);

    // Count saturates at 15 while the sum keeps going
    for (int i = 0; i < 20; i++) send_op(8'd1, i == 19);
    chk("sat_out_valid", out_valid, 1'b1);
    chk("sat_count",     out_count, 15);
    chk("sat_sum",       out_sum,   20);
    chk("sat_ovf",       out_ovf,   1'b0);
    tick();

    // Reset abandons a partial block
    send_op(8'd4, 1'b0);
    send_op(8'd5, 1'b0);
    chk("partial_sum", out_sum, 9);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd50;
    #1;
    chk("rstmid_in_ready",  in_ready,  1'b0);
    chk("rstmid_out_valid", out_valid, 1'b0);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rstmid_sum",   out_sum,   0);
    chk("rstmid_count", out_count, 0);
    chk("rstmid_ovf",   out_ovf,   1'b0);
    chk("rstmid_ready", in_ready,  1'b1);
    send_op(8'd9, 1'b1);
    chk("fresh_valid", out_valid, 1'b1);
    chk("fresh_sum",   out_sum,   9);
    chk("fresh_count", out_count, 1);

    // Reset while a result is pending, with a simultaneous output handshake
    out_ready = 1'b1;
    rst       = 1'b1;
    #1;
    chk("rstdone_out_valid", out_valid, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstdone_valid", out_valid, 1'b0);
    chk("rstdone_sum",   out_sum,   0);
    chk("rstdone_count", out_count, 0);
    chk("rstdone_ready", in_ready,  1'b1);

    // Overflow must not carry into a fresh block
    send_op(8'd200, 1'b0);
    send_op(8'd100, 1'b1);
    tick();
    send_op(8'd7, 1'b1);
    chk("fresh_ovf_clear", out_ovf,   1'b0);
    chk("fresh_ovf_sum",   out_sum,   7);
    chk("fresh_ovf_count", out_count, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/add_accumulator.md
ADD_ACCUMULATOR -- requirements
Module: add_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: operand and accumulator width in bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 8: width of the operand counter.
REQ-003 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1: upstream operand valid.
REQ-006 SHALL have port in_ready  output  1: block accepts an operand this cycle.
REQ-007 SHALL have port in_data  input  DATA_WIDTH: operand to add.
REQ-008 SHALL have port in_last  input  1: the operand is the final one of the current block.
REQ-009 SHALL have port out_valid  output  1: result available.
REQ-010 SHALL have port out_ready  input  1: downstream accepts the result.
REQ-011 SHALL have port out_sum  output  DATA_WIDTH: accumulated sum.
REQ-012 SHALL have port out_ovf  output  1: sticky carry-out seen during the block.
REQ-013 SHALL have port out_count  output  CNT_WIDTH: number of operands accepted in the block.

Function
REQ-014 SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-015 SHALL drive in_ready=1 in IDLE and ACCUM and in_ready=0 in DONE.
REQ-016 SHALL treat an operand as accepted only when in_valid and in_ready are both 1 in the same cycle.
REQ-017 On an accept in IDLE, SHALL load acc <= 0 + in_data, clear ovf, set count=1, and move to ACCUM (or to DONE if in_last=1).
REQ-018 On an accept in ACCUM, SHALL load acc <= acc + in_data and ovf <= ovf | carry-out, and increment count, holding count at 2^CNT_WIDTH-1 (no wrap).
REQ-019 On an accept with in_last=1, SHALL move to DONE; out_valid SHALL be 1 in the cycle after the accepting edge (latency 1).
REQ-020 SHALL hold out_valid, out_sum, out_ovf and out_count stable in DONE until out_valid and out_ready are both 1, then return to IDLE on that edge.
REQ-021 SHALL drive out_valid=0 outside DONE; out_sum, out_ovf and out_count SHALL always reflect the internal registers.
REQ-022 SHALL hold all state when no accept occurs in IDLE or ACCUM.
REQ-023 Addition SHALL be modulo 2^DATA_WIDTH with adder carry-in tied to 0; the carry-out SHALL feed only ovf (and saturation, REQ-027).
REQ-024 Any out_ready value in IDLE or ACCUM SHALL have no effect.

Reset
REQ-025 When rst=1 at a clock edge, SHALL go to IDLE and clear acc, ovf and count to 0; this SHALL also abandon a partial block or a pending DONE result.
REQ-026 While rst=1, SHALL drive in_ready=0 and out_valid=0; rst SHALL take priority over every simultaneous handshake.

Configuration
REQ-027 With macro ADD_ACC_SATURATE_EN defined, SHALL load acc with all-ones whenever an addition's carry-out is 1 (ovf is still set); without the macro, the wrapped sum SHALL be kept.

Structure
REQ-028 SHALL take the state enum (IDLE/ACCUM/DONE) and the default widths from the shared package add_acc_pkg.
REQ-029 SHALL compute the sum by instantiating ripple_carry_adder (DATA_WIDTH, c_in=0) as the single sub-module; the FSM, registers and handshake logic SHALL live in add_accumulator.

Verification (bench instance DATA_WIDTH=8, CNT_WIDTH=4)
REQ-030 Operands 3, 5, 7 with last on 7, out_ready=1 -> out_valid one cycle after the 7 is accepted, out_sum=15, out_ovf=0, out_count=3.
REQ-031 Operands 200, 100 (last) -> out_sum=44 and out_ovf=1; with ADD_ACC_SATURATE_EN, out_sum=255 and out_ovf=1.
REQ-032 out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, no operand accepted; at the first out_ready=1 -> IDLE on the next edge.
REQ-033 Twenty operands of value 1, last on the 20th -> out_count=15 (saturated), out_sum=20.
REQ-034 rst=1 after two accepted operands, or while in DONE -> IDLE next cycle with all outputs 0; the next block starts fresh (single operand 9, last -> out_sum=9, out_count=1).
REQ-035 A single operand with in_last=1 in IDLE -> DONE directly, with out_sum=operand and out_count=1.
